// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: switch contact in, debounced level and edge pulses out.
//   raw     - bouncing mechanical contact (1 = up), driven by master
//   trigger - debounced level (or latched toggle), driven by slave
//   rise    - one-cycle pulse on an accepted 0->1 change
//   fall    - one-cycle pulse on an accepted 1->0 change
//   busy    - high while a candidate change is settling
interface switch_debouncer_if;
    logic raw;
    logic trigger;
    logic rise;
    logic fall;
    logic busy;
    modport master (output raw, input trigger, rise, fall, busy);
    modport slave (input raw, output trigger, rise, fall, busy);
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchronizer plus one-hot settle FSM that turns a
// bouncing switch contact into a clean level with rise/fall pulses.
//   clk - single clock, all state on its rising edge
//   rst - synchronous, active-low reset
//   sw  - switch_debouncer_if.slave (raw in; trigger, rise, fall, busy out)
// Parameters: STABLE_CNT (stable samples to accept, 1..2^CNT_W), CNT_W.
// Macro SWITCH_DEBOUNCER_TOGGLE_EN: trigger latches, inverting on every rise.
module switch_debouncer #(
    parameter int STABLE_CNT = 10,
    parameter int CNT_W      = 4
) (
    input logic clk,
    input logic rst,
    switch_debouncer_if.slave sw
);
    typedef enum logic [3:0] {
        STABLE_LOW  = 4'b0001,
        RISE_WAIT   = 4'b0010,
        STABLE_HIGH = 4'b0100,
        FALL_WAIT   = 4'b1000
    } state_t;

    // Final count value; a change is accepted on the sample where cnt equals it.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic             sync0;
    logic             sync1;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             trigger_q;
    logic             trigger_n;
    logic             rise_q;
    logic             rise_n;
    logic             fall_q;
    logic             fall_n;
    logic             busy_q;
    logic             busy_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            state     <= STABLE_LOW;
            cnt       <= '0;
            trigger_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync0     <= sw.raw;
            sync1     <= sync0;
            state     <= state_n;
            cnt       <= cnt_n;
            trigger_q <= trigger_n;
            rise_q    <= rise_n;
            fall_q    <= fall_n;
            busy_q    <= busy_n;
        end
    end

    // A wait state either falls back on a bounce, accepts on the last count,
    // or keeps counting; cnt is cleared on every state change so it never wraps.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            STABLE_LOW: begin
                if (sync1) begin
                    state_n = RISE_WAIT;
                    cnt_n   = '0;
                end
            end
            RISE_WAIT: begin
                if (!sync1) begin
                    state_n = STABLE_LOW;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = STABLE_HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!sync1) begin
                    state_n = FALL_WAIT;
                    cnt_n   = '0;
                end
            end
            FALL_WAIT: begin
                if (sync1) begin
                    state_n = STABLE_HIGH;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = STABLE_LOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = STABLE_LOW;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are computed from the transition and registered alongside state.
    always_comb begin
        rise_n = state == RISE_WAIT && state_n == STABLE_HIGH;
        fall_n = state == FALL_WAIT && state_n == STABLE_LOW;
        busy_n = state_n == RISE_WAIT || state_n == FALL_WAIT;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
        trigger_n = rise_n ? !trigger_q : trigger_q;
`else
        trigger_n = state_n == STABLE_HIGH || state_n == FALL_WAIT;
`endif
    end

    assign sw.trigger = trigger_q;
    assign sw.rise    = rise_q;
    assign sw.fall    = fall_q;
    assign sw.busy    = busy_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random checks of two debouncers
// (STABLE_CNT=10 and STABLE_CNT=1) against a run-length reference model.
module tb_switch_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic raw = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    switch_debouncer_if bus0 ();
    switch_debouncer_if bus1 ();
    assign bus0.raw = raw;
    assign bus1.raw = raw;

    switch_debouncer #(.STABLE_CNT(10), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .sw(bus0.slave));
    switch_debouncer #(.STABLE_CNT(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .sw(bus1.slave));

    // Model: a new level is accepted once the synchronized input has disagreed
    // with the current level for STABLE_CNT+1 consecutive samples.
    int   n_req[2] = '{10, 1};
    logic m_s0[2], m_s1[2], m_lvl[2], m_trig[2], m_rise[2], m_fall[2], m_busy[2];
    int   m_run[2];

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_s0[d] = 0; m_s1[d] = 0; m_lvl[d] = 0; m_trig[d] = 0;
                m_rise[d] = 0; m_fall[d] = 0; m_busy[d] = 0; m_run[d] = 0;
            end else begin
                m_rise[d] = 0;
                m_fall[d] = 0;
                m_run[d] = (m_s1[d] != m_lvl[d]) ? m_run[d] + 1 : 0;
                if (m_run[d] == n_req[d] + 1) begin
                    m_lvl[d] = !m_lvl[d];
                    m_rise[d] = m_lvl[d];
                    m_fall[d] = !m_lvl[d];
                    m_run[d] = 0;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
                    if (m_rise[d]) m_trig[d] = !m_trig[d];
`endif
                end
`ifndef SWITCH_DEBOUNCER_TOGGLE_EN
                m_trig[d] = m_lvl[d];
`endif
                m_busy[d] = m_run[d] != 0;
                m_s1[d] = m_s0[d];
                m_s0[d] = raw;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic check_all();
        check("d0.trigger", 32'(bus0.trigger), 32'(m_trig[0]));
        check("d0.rise", 32'(bus0.rise), 32'(m_rise[0]));
        check("d0.fall", 32'(bus0.fall), 32'(m_fall[0]));
        check("d0.busy", 32'(bus0.busy), 32'(m_busy[0]));
        check("d1.trigger", 32'(bus1.trigger), 32'(m_trig[1]));
        check("d1.rise", 32'(bus1.rise), 32'(m_rise[1]));
        check("d1.fall", 32'(bus1.fall), 32'(m_fall[1]));
        check("d1.busy", 32'(bus1.busy), 32'(m_busy[1]));
    endtask

    // Inputs change only between edges; outputs are checked on the falling edge.
    task automatic step(input logic r, input logic rs);
        raw = r;
        rst = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int   lat0, lat1, falls;
        logic seen;
        repeat (3) step(0, 0);
        repeat (20) step(0, 1);
        lat0 = -1;
        lat1 = -1;
        for (int i = 0; i < 30; i++) begin
            step(1, 1);
            if (lat0 < 0 && bus0.trigger) lat0 = i;
            if (lat1 < 0 && bus1.trigger) lat1 = i;
        end
`ifndef SWITCH_DEBOUNCER_TOGGLE_EN
        check("latency_default", 32'(lat0), 32'd12);
        check("latency_cnt1", 32'(lat1), 32'd3);
`endif
        repeat (20) step(0, 1);
        seen = 0;
        step(1, 1); seen |= bus0.busy;
        step(0, 1); seen |= bus0.busy;
        step(1, 1); seen |= bus0.busy;
        step(0, 1); seen |= bus0.busy;
        repeat (15) begin
            step(0, 1);
            seen |= bus0.busy;
        end
        check("bounce_busy_seen", 32'(seen), 32'd1);
        check("bounce_trigger", 32'(bus0.trigger), 32'd0);
        repeat (15) step(1, 1);
        repeat (9) step(0, 1);
        falls = 0;
        repeat (15) begin
            step(1, 1);
            falls += int'(bus0.fall);
        end
        check("short_low_no_fall", 32'(falls), 32'd0);
        repeat (15) begin
            step(0, 1);
            falls += int'(bus0.fall);
        end
        check("long_low_one_fall", 32'(falls), 32'd1);
        repeat (20) step(0, 1);
        repeat (8) step(1, 1);
        check("settling_busy", 32'(bus0.busy), 32'd1);
        step(1, 0);
        check("reset_mid_settle", {28'd0, bus0.trigger, bus0.rise, bus0.fall, bus0.busy}, 32'd0);
        repeat (20) step(1, 1);
        for (int k = 0; k < 3; k++) begin
            repeat (15) step(1, 1);
            repeat (15) step(0, 1);
        end
        for (int k = 0; k < 150; k++) begin
            logic lv;
            int   len;
            lv = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 16);
            step(lv, ($urandom_range(0, 29) != 0));
            repeat (len - 1) step(lv, 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 10: consecutive stable synchronized samples required to accept a level change; legal range 1..2^CNT_W.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the settle counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port raw, input, 1 bit: asynchronous, bouncing mechanical switch contact (1 = up).
REQ-006 The block SHALL have port trigger, output, 1 bit: debounced switch level (1 = FlipUp, 0 = FlipDown), driven straight into the light-switch FSM trigger input.
REQ-007 The block SHALL have port rise, output, 1 bit: one-cycle pulse on an accepted 0->1 change.
REQ-008 The block SHALL have port fall, output, 1 bit: one-cycle pulse on an accepted 1->0 change.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a candidate change is settling.

Function
REQ-010 raw SHALL pass through a two-flip-flop synchronizer (sync0 -> sync1); only sync1 feeds the logic.
REQ-011 The control FSM SHALL be one-hot, 4 bits: StableLow=0001, RiseWait=0010, StableHigh=0100, FallWait=1000.
REQ-012 In StableLow, sync1=1 SHALL move to RiseWait with cnt cleared to 0; otherwise the FSM stays.
REQ-013 In RiseWait with sync1=0 (bounce), the FSM SHALL return to StableLow, clear cnt, and pulse nothing.
REQ-014 In RiseWait with sync1=1 and cnt<STABLE_CNT-1, cnt SHALL increment by 1.
REQ-015 In RiseWait with sync1=1 and cnt=STABLE_CNT-1, the FSM SHALL move to StableHigh, clear cnt, and assert rise for exactly the next cycle.
REQ-016 StableHigh and FallWait SHALL mirror REQ-012 to REQ-015 with polarities inverted; the accepted change asserts fall.
REQ-017 Latency SHALL be a trigger change STABLE_CNT+2 rising edges after the edge on which sync0 first captured a held raw change; at the default this is 12 edges.
REQ-018 trigger, rise, fall and busy SHALL be registered outputs; busy=1 exactly when the state is RiseWait or FallWait.
REQ-019 rise and fall SHALL never both be 1 in the same cycle; the pulses of two successive accepted changes SHALL be at least STABLE_CNT+1 cycles apart.
REQ-020 cnt SHALL never wrap; an illegal (non-one-hot) state SHALL recover to StableLow on the next edge.

Reset
REQ-021 With rst=0 at a clk edge, sync0, sync1 and cnt SHALL be 0, state SHALL be StableLow, and trigger, rise, fall and busy SHALL be 0.
REQ-022 Reset SHALL dominate all other inputs, including during settling; a settling change is discarded with no pulse.
REQ-023 After release, a raw input held at 1 SHALL be accepted as a normal 0->1 change per REQ-017.

Configuration
REQ-024 Macro SWITCH_DEBOUNCER_TOGGLE_EN SHALL select the trigger behaviour.
- Undefined: trigger SHALL equal the debounced level (1 in StableHigh and FallWait).
- Defined: trigger SHALL invert on each rise pulse and ignore fall, converting a momentary push-button into a latching switch; reset value 0; rise, fall and busy are unchanged.

Verification
REQ-025 Reset, then hold raw=1 from edge 0 (defaults): trigger=0 through edge 11, then 1 from edge 12; rise=1 for the single cycle after edge 12; fall=0 throughout.
REQ-026 From StableLow, toggle raw 1,0,1,0 on successive edges, then hold 0: busy pulses, trigger stays 0, rise and fall stay 0, and the state returns to StableLow.
REQ-027 From StableHigh, raw=0 for 9 cycles, then 1: no fall pulse, trigger stays 1; raw=0 held for 12 or more cycles: fall pulses once and trigger=0.
REQ-028 Assert rst=0 for one cycle while the design is in RiseWait with cnt=5: all outputs are 0 on the next edge, with no rise pulse.
REQ-029 With SWITCH_DEBOUNCER_TOGGLE_EN defined, apply three clean presses (raw 1 for 15 cycles, 0 for 15 cycles): trigger goes 0->1->0->1, one transition per rise pulse.
REQ-030 With STABLE_CNT=1, a held raw change SHALL change trigger after 3 edges.
